// File: rtl/btn_strobe_gen_if.sv
// btn_strobe_gen_if
//   Groups the push-button inputs and the conditioned level/strobe outputs
//   of btn_strobe_gen into one bundle.
//   master : drives the raw buttons, observes levels and strobes
//   slave  : the conditioning block (btn_strobe_gen)
//   Signals:
//     button_red / button_wrd : raw read/write buttons, asynchronous, active-high
//     rd_level   / wr_level   : debounced button levels
//     rd_pulse   / wr_pulse   : one-clock read/write strobes (never together)
//     pend                    : a deferred strobe is waiting to fire
interface btn_strobe_gen_if;
   logic button_red;
   logic button_wrd;
   logic rd_level;
   logic wr_level;
   logic rd_pulse;
   logic wr_pulse;
   logic pend;

   modport master (
      output button_red,
      output button_wrd,
      input  rd_level,
      input  wr_level,
      input  rd_pulse,
      input  wr_pulse,
      input  pend
   );

   modport slave (
      input  button_red,
      input  button_wrd,
      output rd_level,
      output wr_level,
      output rd_pulse,
      output wr_pulse,
      output pend
   );
endinterface

// File: rtl/btn_strobe_gen.sv
// btn_strobe_gen
//   Conditions the raw read/write push-buttons for the board-level FIFO.
//   Each button is synchronised (two flops), debounced (must be stable for
//   2^N clocks) and rising-edge detected. Rising edges become single-clock
//   registered strobes. Simultaneous rises are serialised: the priority
//   strobe (write when WR_FIRST=1) fires first, the other is held in a
//   pending flag and fires on the following clock.
//   Ports:
//     clk : system clock
//     clr : asynchronous active-high reset, clears every flop
//     bus : btn_strobe_gen_if.slave (buttons in; levels, strobes, pend out)
//   Parameters:
//     N        : debounce counter width (stable time = 2^N clocks)
//     WR_FIRST : 1 = write wins a simultaneous press, 0 = read wins
module btn_strobe_gen #(
   parameter int N        = 19,
   parameter bit WR_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             clr,
   btn_strobe_gen_if.slave  bus
);

   // Channel index 0 = read button, 1 = write button.
   localparam logic [N-1:0] CNT_MAX = '1;

   logic [1:0]   s1;
   logic [1:0]   s2;
   logic [1:0]   lvl;
   logic [1:0]   lvl_d;
   logic [N-1:0] cnt [2];
   logic [1:0]   rise;

   logic rd_pulse_q, wr_pulse_q;
   logic pend_rd, pend_wr;
   logic rd_nxt, wr_nxt, pend_rd_nxt, pend_wr_nxt;

   // Synchroniser, debounce counter and level history for both channels.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         s1    <= '0;
         s2    <= '0;
         lvl   <= '0;
         lvl_d <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1    <= {bus.button_wrd, bus.button_red};
         s2    <= s1;
         lvl_d <= lvl;
         for (int unsigned i = 0; i < 2; i++) begin
            if (s2[i] == lvl[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               // Stable for 2^N consecutive clocks: accept the new level.
               lvl[i] <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + N'(1);
            end
         end
      end
   end

   assign rise = lvl & ~lvl_d;

   // Strobe arbitration. A pending strobe always goes out before any new
   // rise; a rise that cannot be issued this cycle is parked in its pending
   // flag so at most one strobe is emitted per clock.
   always_comb begin
      rd_nxt      = 1'b0;
      wr_nxt      = 1'b0;
      pend_rd_nxt = 1'b0;
      pend_wr_nxt = 1'b0;
      if (pend_rd) begin
         rd_nxt      = 1'b1;
         pend_rd_nxt = rise[0];
         pend_wr_nxt = pend_wr | rise[1];
      end else if (pend_wr) begin
         wr_nxt      = 1'b1;
         pend_rd_nxt = rise[0];
         pend_wr_nxt = rise[1];
      end else if (rise[0] && rise[1]) begin
         if (WR_FIRST) begin
            wr_nxt      = 1'b1;
            pend_rd_nxt = 1'b1;
         end else begin
            rd_nxt      = 1'b1;
            pend_wr_nxt = 1'b1;
         end
      end else begin
         rd_nxt = rise[0];
         wr_nxt = rise[1];
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rd_pulse_q <= 1'b0;
         wr_pulse_q <= 1'b0;
         pend_rd    <= 1'b0;
         pend_wr    <= 1'b0;
      end else begin
         rd_pulse_q <= rd_nxt;
         wr_pulse_q <= wr_nxt;
         pend_rd    <= pend_rd_nxt;
         pend_wr    <= pend_wr_nxt;
      end
   end

   assign bus.rd_level = lvl[0];
   assign bus.wr_level = lvl[1];
   assign bus.rd_pulse = rd_pulse_q;
   assign bus.wr_pulse = wr_pulse_q;
   assign bus.pend     = pend_rd | pend_wr;

endmodule
